// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the nibble-serial add sequencer.
package serial_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nibble counter width: clog2 of the nibble count, never below one bit.
  function automatic int unsigned cnt_w(input int unsigned nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_csa4.sv
// 4-bit carry-select adder: 2-bit ripple low half, precomputed high half for both carries.
module csa4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [2:0] lo;
  logic [2:0] hi0;
  logic [2:0] hi1;

  assign lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, ci};
  assign hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
  assign hi1 = hi0 + 3'd1;

  // Low-half carry picks which precomputed upper half is used.
  assign s  = {(lo[2] ? hi1[1:0] : hi0[1:0]), lo[1:0]};
  assign co = lo[2] ? hi1[2] : hi0[2];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-precision add sequencer feeding one csa4 a nibble per cycle, LSB first.
// Optional SERIAL_ADDER_SUB_EN adds a 'sub' port selecting A-B instead of A+B+cin.
module nibble_serial_adder
  import serial_adder_pkg::*;
#(
  parameter  int unsigned NIBBLES = 4,
  localparam int unsigned WIDTH   = NIBBLE_W * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned   CW   = cnt_w(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    sum_q;
  logic [CW-1:0]       cnt_q;
  logic                carry_q;
  logic                cout_q;
  logic                out_valid_q;
  logic                in_ready_q;
  logic                carry_init_c;

  logic                accept_c;
  logic                step_c;
  logic                last_c;

  logic [NIBBLE_W-1:0] nib_a_c;
  logic [NIBBLE_W-1:0] nib_b_raw_c;
  logic [NIBBLE_W-1:0] nib_b_c;
  logic [NIBBLE_W-1:0] nib_s_c;
  logic                nib_co_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    step_c    = 1'b0;
    last_c    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          accept_c  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (cnt_q == LAST) begin
          last_c    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // A new request in this cycle is deliberately left for IDLE.
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sub_q <= 1'b0;
    else if (accept_c) sub_q <= sub;
  end

  // Subtraction is A + ~B + 1, so cin is ignored when sub is set.
  assign carry_init_c = sub ? 1'b1 : cin;
  assign nib_b_c      = nib_b_raw_c ^ {NIBBLE_W{sub_q}};
`else
  assign carry_init_c = cin;
  assign nib_b_c      = nib_b_raw_c;
`endif

  // Select the operand nibbles addressed by the counter
  always_comb begin
    nib_a_c     = '0;
    nib_b_raw_c = '0;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (cnt_q == CW'(i)) begin
        nib_a_c     = a_q[i*NIBBLE_W +: NIBBLE_W];
        nib_b_raw_c = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  csa4 u_csa4 (
    .a  (nib_a_c),
    .b  (nib_b_c),
    .ci (carry_q),
    .s  (nib_s_c),
    .co (nib_co_c)
  );

  // Operand capture, nibble counter and chained carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept_c) begin
      a_q     <= op_a;
      b_q     <= op_b;
      cnt_q   <= '0;
      carry_q <= carry_init_c;
    end else if (step_c) begin
      cnt_q   <= last_c ? '0 : cnt_q + CW'(1);
      carry_q <= nib_co_c;
    end
  end

  // Result assembly; held untouched through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (step_c) begin
      for (int i = 0; i < int'(NIBBLES); i++) begin
        if (cnt_q == CW'(i)) sum_q[i*NIBBLE_W +: NIBBLE_W] <= nib_s_c;
      end
      if (last_c) cout_q <= nib_co_c;
    end
  end

  // Handshake flags track the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_nxt == IDLE);
      out_valid_q <= (state_nxt == DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench: 4-nibble instance plus a 1-nibble instance.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [15:0] op_a, op_b, sum;
  logic        in_valid_1, in_ready_1, cin_1, out_valid_1, out_ready_1, cout_1;
  logic [3:0]  op_a_1, op_b_1, sum_1;
`ifdef SERIAL_ADDER_SUB_EN
  logic        sub, sub_1;
`endif

  int errors = 0;
  int checks = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .op_a(op_a_1), .op_b(op_b_1), .cin(cin_1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_1),
`endif
    .out_valid(out_valid_1), .out_ready(out_ready_1), .sum(sum_1), .cout(cout_1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present operands (called at posedge+1); returns once the accepting edge has passed.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          output bit ok);
    int k;
    in_valid = 1'b1; op_a = a; op_b = b; cin = c;
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    ok = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Cycle index (accepting cycle = 0) at which out_valid is first seen.
  task automatic wait_valid(output int k);
    k = 1;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1; k++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h exp 0000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b exp 0", cout); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    logic [15:0] va [2] = '{16'hFFFF, 16'hFFFF};
    logic [15:0] vb [2] = '{16'h0001, 16'hFFFF};
    logic        vc [2] = '{1'b0, 1'b1};
    logic [15:0] es [2] = '{16'h0000, 16'hFFFF};
    bit ok;
    int k;
    for (int i = 0; i < 2; i++) begin
      start_op(va[i], vb[i], vc[i], ok);
      checks++; if (!ok) begin errors++; $display("FAIL wrap%0d_accept: in_ready never high", i); end
      wait_valid(k);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap%0d_timeout: out_valid got %b exp 1", i, out_valid); end
      checks++; if (sum !== es[i]) begin errors++; $display("FAIL wrap%0d_sum: got %h exp %h", i, sum, es[i]); end
      checks++; if (cout !== 1'b1) begin errors++; $display("FAIL wrap%0d_cout: got %b exp 1", i, cout); end
      retire();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap%0d_retire: out_valid got %b exp 0", i, out_valid); end
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int k;
    start_op(16'h5555, 16'h1111, 1'b0, ok);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b exp 0", out_valid); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL midrst_sum: got %h exp 0000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midrst_cout: got %b exp 0", cout); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b exp 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(16'h1234, 16'h1111, 1'b0, ok);
    wait_valid(k);
    checks++; if (sum !== 16'h2345 || out_valid !== 1'b1) begin errors++; $display("FAIL midrst_after_sum: got %h valid %b exp 2345 valid 1", sum, out_valid); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midrst_after_cout: got %b exp 0", cout); end
    retire();
  endtask

  task automatic test_latency_backpressure();
    bit ok;
    int k;
    start_op(16'h0F0F, 16'h0101, 1'b0, ok);
    wait_valid(k);
    checks++; if (k != 5) begin errors++; $display("FAIL latency: got %0d cycles exp 5", k); end
    checks++; if (sum !== 16'h1010) begin errors++; $display("FAIL bp_sum_first: got %h exp 1010", sum); end
    // Extra request during DONE must be ignored.
    in_valid = 1'b1; op_a = 16'h7777; op_b = 16'h7777; cin = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || sum !== 16'h1010 || cout !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid %b sum %h cout %b in_ready %b exp 1 1010 0 0", c, out_valid, sum, cout, in_ready);
      end
    end
    in_valid = 1'b0;
    retire();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int k;
    start_op(16'hABCD, 16'h1234, 1'b0, ok);
    wait_valid(k);
    checks++; if (sum !== 16'hBE01 || cout !== 1'b0) begin errors++; $display("FAIL b2b_first: got %h/%b exp be01/0", sum, cout); end
    out_ready = 1'b1;
    in_valid = 1'b1; op_a = 16'h8000; op_b = 16'h8000; cin = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_retire: out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_no_accept: in_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept: in_ready got %b exp 0", in_ready); end
    wait_valid(k);
    checks++; if (k != 5) begin errors++; $display("FAIL b2b_latency: got %0d exp 5", k); end
    checks++; if (sum !== 16'h0001 || cout !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h/%b exp 0001/1", sum, cout); end
    retire();
  endtask

  task automatic test_nibbles1();
    int k;
    in_valid_1 = 1'b1; op_a_1 = 4'h9; op_b_1 = 4'h8; cin_1 = 1'b1;
    checks++; if (in_ready_1 !== 1'b1) begin errors++; $display("FAIL n1_in_ready: got %b exp 1", in_ready_1); end
    @(posedge clk); #1;
    in_valid_1 = 1'b0;
    k = 1;
    while (!out_valid_1 && k < 20) begin
      @(posedge clk); #1; k++;
    end
    checks++; if (k != 2) begin errors++; $display("FAIL n1_latency: got %0d exp 2", k); end
    checks++; if (sum_1 !== 4'h2 || cout_1 !== 1'b1) begin errors++; $display("FAIL n1_result: got %h/%b exp 2/1", sum_1, cout_1); end
    out_ready_1 = 1'b1;
    @(posedge clk); #1;
    out_ready_1 = 1'b0;
    checks++; if (out_valid_1 !== 1'b0) begin errors++; $display("FAIL n1_retire: out_valid got %b exp 0", out_valid_1); end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    bit ok;
    int k;
    sub = 1'b1;
    start_op(16'h0005, 16'h0007, 1'b0, ok);
    sub = 1'b0;
    wait_valid(k);
    checks++; if (sum !== 16'hFFFE || cout !== 1'b0) begin errors++; $display("FAIL sub_borrow: got %h/%b exp fffe/0", sum, cout); end
    retire();
    sub = 1'b1;
    start_op(16'h0007, 16'h0005, 1'b0, ok);
    sub = 1'b0;
    wait_valid(k);
    checks++; if (sum !== 16'h0002 || cout !== 1'b1) begin errors++; $display("FAIL sub_noborrow: got %h/%b exp 0002/1", sum, cout); end
    retire();
  endtask
`endif

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    in_valid_1 = 1'b0; out_ready_1 = 1'b0; op_a_1 = '0; op_b_1 = '0; cin_1 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0; sub_1 = 1'b0;
`endif
    test_reset();
    test_wrap();
    test_reset_mid_run();
    test_latency_backpressure();
    test_back_to_back();
    test_nibbles1();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
